// File: rtl/key_schedule_engine.sv
// Iterative AES key expansion (128/192/256-bit keys): one schedule word per cycle,
// each completed 128-bit round key handed out over a back-pressurable valid/ready stream.
module key_schedule_engine #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key,
    input  logic                    abort,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [127:0]            rk_data,
    output logic [3:0]              rk_index,
    output logic                    busy,
    output logic                    done
);

    localparam int NKMAX = MAX_KEY_BITS / 32;
    localparam int KW    = (NKMAX > 1) ? $clog2(NKMAX) : 1;
    localparam int WINW  = NKMAX * 32;

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

    state_t                  state, state_n;
    logic [MAX_KEY_BITS-1:0] key_q;
    logic [KW-1:0]           nk_m1;
    logic [3:0]              nr_q;
    logic [5:0]              widx;
    logic [KW-1:0]           kcnt;
    logic [7:0]              rcon;
    logic [WINW-1:0]         win_q;
    logic [95:0]             asm_q;

    logic                    legal, accept, last_grp, stall, produce, in_key, final_hs;
    logic [5:0]              wlast;
    logic [31:0]             prev_w, oldest_w, temp_w, new_w;
    logic [WINW-1:0]         win_sh;
    logic [MAX_KEY_BITS-1:0] key_sh;

    function automatic int nk_of(input logic [1:0] kl);
        case (kl)
            2'd0:    return 4;
            2'd1:    return 6;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, bb;
        p  = '0;
        x  = a;
        bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254 in GF(2^8)) followed by the AES affine map.
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int n = 0; n < 7; n++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
    endfunction

    assign legal    = (key_len != 2'd3) && (nk_of(key_len) * 32 <= MAX_KEY_BITS);
    assign accept   = (state == IDLE) && start && !abort && legal;
    assign last_grp = (widx[1:0] == 2'b11);
    // Only the word that closes a round key waits on the output register.
    assign stall    = last_grp && rk_valid && !rk_ready;
    assign produce  = (state == GEN) && !abort && !stall;
    assign in_key   = (widx <= 6'(nk_m1));
    assign wlast    = {nr_q, 2'b11};
    assign final_hs = (state == DRAIN) && !abort && rk_valid && rk_ready && (rk_index == nr_q);

    always_comb begin
        win_sh   = win_q >> {nk_m1, 5'b0};
        key_sh   = key_q << {kcnt, 5'b0};
        prev_w   = win_q[31:0];
        oldest_w = win_sh[31:0];
        temp_w   = prev_w;
        if (kcnt == '0) begin
            temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h0};
        end else if ((32'(nk_m1) == 7) && (32'(kcnt) == 4)) begin
            temp_w = sub_word(prev_w);
        end
        new_w = in_key ? key_sh[MAX_KEY_BITS-1 -: 32] : (oldest_w ^ temp_w);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = final_hs;
        busy    = (state != IDLE) && !final_hs;
        case (state)
            IDLE:    if (accept) state_n = GEN;
            GEN: begin
                if (abort)                          state_n = IDLE;
                else if (produce && (widx == wlast)) state_n = DRAIN;
            end
            DRAIN: begin
                if (abort || final_hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Word generation and round-key output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q    <= '0;
            nk_m1    <= '0;
            nr_q     <= '0;
            widx     <= '0;
            kcnt     <= '0;
            rcon     <= '0;
            win_q    <= '0;
            asm_q    <= '0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
        end else begin
            if (accept) begin
                key_q <= key;
                nk_m1 <= KW'(nk_of(key_len) - 1);
                nr_q  <= 4'(nk_of(key_len) + 6);
                widx  <= '0;
                kcnt  <= '0;
                rcon  <= 8'h01;
            end
            if (rk_valid && rk_ready) rk_valid <= 1'b0;
            if (produce) begin
                widx  <= widx + 6'd1;
                kcnt  <= (kcnt == nk_m1) ? '0 : kcnt + 1'b1;
                if ((kcnt == '0) && !in_key) rcon <= xtime(rcon);
                win_q <= {win_q[WINW-33:0], new_w};
                asm_q <= {asm_q[63:0], new_w};
                if (last_grp) begin
                    rk_data  <= {asm_q, new_w};
                    rk_index <= widx[5:2];
                    rk_valid <= 1'b1;
                end
            end
            if (abort && (state != IDLE)) rk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_schedule_engine.sv
// Scoreboard bench for key_schedule_engine: a reference key expansion queues the expected
// round keys at each start; a negedge monitor pops and compares every accepted round key.
module tb_key_schedule_engine;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         abort;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;

    key_schedule_engine #(.MAX_KEY_BITS(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key      (key),
        .abort    (abort),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done)
    );

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           c0 = 0;
    int           first_cyc = -1;
    int           done_cyc = -1;
    int           done_cnt = 0;
    int           done_base = 0;
    int           keys_rx = 0;
    logic         rand_en = 1'b0;
    logic [7:0]   sbox_t [256];
    logic [31:0]  mw [$];
    logic [131:0] exp_q [$];
    logic [127:0] got [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = rand_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Classic generator walk: p steps by x3, q by /3, so q = p^-1 each step.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ ((q << 1) | (q >> 7)) ^ ((q << 2) | (q >> 6)) ^
                ((q << 3) | (q >> 5)) ^ ((q << 4) | (q >> 4));
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic model_push(input logic [1:0] kl, input logic [255:0] k);
        int nk, nr;
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [255:0] sh;
        nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nr = nk + 6;
        rc = 8'h01;
        mw.delete();
        for (int i = 0; i < nk; i++) begin
            sh = k << (32 * i);
            mw.push_back(sh[255:224]);
        end
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i - 1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            mw.push_back(mw[i - nk] ^ t);
        end
        for (int r = 0; r <= nr; r++)
            exp_q.push_back({4'(r), mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]});
    endtask

    task automatic launch(input logic [1:0] kl, input logic [255:0] k);
        model_push(kl, k);
        keys_rx   = 0;
        done_base = done_cnt;
        @(posedge clk);
        #1;
        start   = 1'b1;
        key_len = kl;
        key     = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic wait_done(input string nm, input int nr, input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_done_seen"}, 128'(done_cnt > done_base), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_done_count"}, 128'(done_cnt - done_base), 128'd1);
        check({nm, "_key_count"}, 128'(keys_rx), 128'(nr + 1));
        check({nm, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
        check({nm, "_busy_after"}, 128'(busy), 128'd0);
    endtask

    // Monitor: pops expectations on every handshake and checks hold stability.
    initial begin
        logic         prev_hold;
        logic [127:0] prev_data;
        logic [3:0]   prev_idx;
        logic [131:0] e;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_idx  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checks++;
                    if (!(rk_valid && rk_data == prev_data && rk_index == prev_idx)) begin
                        errors++;
                        $display("FAIL hold_stable actual=%0b/%0d/%h required=1/%0d/%h",
                                 rk_valid, rk_index, rk_data, prev_idx, prev_data);
                    end
                end
                if (rk_valid && rk_ready) begin
                    got[rk_index] = rk_data;
                    keys_rx++;
                    if (rk_index == 4'd0) first_cyc = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rk_unexpected actual=%0d:%h required=none", rk_index, rk_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rk_index, rk_data} !== e) begin
                            errors++;
                            $display("FAIL rk_seq actual=%0d:%h required=%0d:%h",
                                     rk_index, rk_data, e[131:128], e[127:0]);
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_hold = rk_valid && !rk_ready;
                prev_data = rk_data;
                prev_idx  = rk_index;
            end
        end
    end

    initial begin
        logic reached;
        int   n;
        start   = 1'b0;
        abort   = 1'b0;
        key_len = 2'd0;
        key     = '0;
        rst     = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rk_valid", 128'(rk_valid), 128'd0);
        check("reset_rk_data", rk_data, 128'd0);
        check("reset_rk_index", 128'(rk_index), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        rst = 1'b1;

        launch(2'd0, K128);
        wait_done("k128", 10, 200);
        check("k128_rk0_latency", 128'(first_cyc), 128'(c0 + 4));
        check("k128_done_latency", 128'(done_cyc), 128'(c0 + 44));
        check("k128_rk0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("k128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("k128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        launch(2'd1, K192);
        wait_done("k192", 12, 200);
        check("k192_w6", 128'(got[1][63:32]), 128'h0fe0c91f7);
        check("k192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        launch(2'd2, K256);
        wait_done("k256", 14, 200);
        check("k256_rk2_w8", 128'(got[2][127:96]), 128'h09ba35411);
        check("k256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        rand_en = 1'b1;
        launch(2'd2, K256);
        wait_done("k256_bp", 14, 1000);
        rand_en = 1'b0;
        check("k256_bp_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        launch(2'd0, K128);
        reached = 1'b0;
        n = 0;
        while (!reached && n < 200) begin
            @(negedge clk);
            if (rk_valid && rk_index == 4'd5) reached = 1'b1;
            n++;
        end
        check("abort_reach_idx5", 128'(reached), 128'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_rk_valid", 128'(rk_valid), 128'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 128'(done_cnt - done_base), 128'd0);
        launch(2'd0, K128);
        wait_done("after_abort", 10, 200);

        @(posedge clk);
        #1;
        start   = 1'b1;
        key_len = 2'd3;
        key     = K256;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("illegal_busy", 128'(busy), 128'd0);
        check("illegal_rk_valid", 128'(rk_valid), 128'd0);

        launch(2'd0, K128);
        repeat (10) @(posedge clk);
        #1;
        start   = 1'b1;
        key_len = 2'd2;
        key     = K256;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_busy", 10, 200);
        check("start_busy_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        launch(2'd2, K256);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_rk_valid", 128'(rk_valid), 128'd0);
        check("arst_rk_data", rk_data, 128'd0);
        check("arst_rk_index", 128'(rk_index), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_done", 128'(done), 128'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("arst_stays_idle", 128'(busy), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
